// File: rtl/mdr_nibble_fetch.sv
// Nibble-serial word fetch for the 16-bit MDR: issues four nibble reads MS-first
// and steers each returning nibble into the MDR with a one-hot enable.
module mdr_nibble_fetch #(
    parameter int ADDR_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_mem_rd,
    output logic [ADDR_W+1:0] o_mem_addr,
    output logic [3:0]        o_mdr_en
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    localparam logic [1:0] DRAIN_LAST = 2'(READ_LAT - 1);

    state_t                   r_state, w_state_nxt;
    logic [ADDR_W-1:0]        r_word, w_word_nxt;
    logic [1:0]               r_k, w_k_nxt;
    logic [1:0]               r_dcnt, w_dcnt_nxt;
    logic                     r_busy, r_done, r_mem_rd;
    logic [ADDR_W+1:0]        r_mem_addr;
    logic                     w_done_nxt, w_rd_nxt;
    logic [ADDR_W+1:0]        w_maddr_nxt;
    logic [3:0]               w_slot_nxt;
    // Stage 0 mirrors the issue slot; stage READ_LAT lines up with returning data.
    logic [READ_LAT:0][3:0]   r_en_pipe;

    always_comb begin
        w_state_nxt = r_state;
        w_word_nxt  = r_word;
        w_k_nxt     = r_k;
        w_dcnt_nxt  = r_dcnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_ISSUE;
                    w_word_nxt  = i_addr;
                    w_k_nxt     = 2'd0;
                end
            end
            S_ISSUE: begin
                if (r_k == 2'd3) begin
                    w_state_nxt = S_DRAIN;
                    w_dcnt_nxt  = 2'd0;
                end else begin
                    w_k_nxt = r_k + 2'd1;
                end
            end
            S_DRAIN: begin
                if (r_dcnt == DRAIN_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_dcnt_nxt = r_dcnt + 2'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Outputs are computed from next state so every port comes straight off a flop.
        w_rd_nxt    = (w_state_nxt == S_ISSUE);
        w_maddr_nxt = w_rd_nxt ? {w_word_nxt, w_k_nxt} : r_mem_addr;
        w_slot_nxt  = w_rd_nxt ? (4'b1000 >> w_k_nxt) : 4'b0000;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state    <= S_IDLE;
            r_word     <= '0;
            r_k        <= 2'd0;
            r_dcnt     <= 2'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
            r_en_pipe  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_word     <= w_word_nxt;
            r_k        <= w_k_nxt;
            r_dcnt     <= w_dcnt_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= w_done_nxt;
            r_mem_rd   <= w_rd_nxt;
            r_mem_addr <= w_maddr_nxt;
            r_en_pipe[0] <= w_slot_nxt;
            for (int i = 1; i <= READ_LAT; i++) r_en_pipe[i] <= r_en_pipe[i-1];
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_mem_rd   = r_mem_rd;
    assign o_mem_addr = r_mem_addr;
    assign o_mdr_en   = r_en_pipe[READ_LAT];

endmodule

// File: tb/tb_mdr_nibble_fetch.sv
// Scoreboard bench: two fetchers (READ_LAT 1 and 4) share random stimulus; each has
// its own reference schedule, memory model and MDR model.
module tb_mdr_nibble_fetch;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [3:0] mem [1024];
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    bit         armed = 1'b0;
    int         pend [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int inst, input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL rl%0d %s cyc=%0d actual=%0h expected=%0h", inst, nm, cyc, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int RL = (g == 0) ? 1 : 4;
        logic       busy, done, rd;
        logic [9:0] maddr;
        logic [3:0] en;
        ev_t        mq[$], eq[$], dq[$];
        ev_t        e;
        int         hist [8];
        logic [15:0] mdr;
        logic [3:0]  data;
        int         bfrom, buntil, e0, a;

        mdr_nibble_fetch #(.ADDR_W(8), .READ_LAT(RL)) u_dut (
            .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_addr(addr),
            .o_busy(busy), .o_done(done), .o_mem_rd(rd), .o_mem_addr(maddr),
            .o_mdr_en(en)
        );

        a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(en))
            else $error("FAIL rl%0d assert onehot0 en=%b", RL, en);
        a_done:   assert property (@(posedge clk) disable iff (!rst_n) done |-> !busy)
            else $error("FAIL rl%0d assert done_busy", RL);
        a_rd:     assert property (@(posedge clk) disable iff (!rst_n) rd |-> busy)
            else $error("FAIL rl%0d assert rd_busy", RL);

        initial begin
            bfrom = 0; buntil = -1; mdr = '0;
            for (int i = 0; i < 8; i++) hist[i] = -1;
            pend[g] = 0;
            forever begin
                @(negedge clk);
                if (armed) begin
                    chk(RL, "busy", busy, (cyc >= bfrom && cyc <= buntil));
                    chk(RL, "onehot0", $onehot0(en), 1);
                    chk(RL, "done_and_busy", done & busy, 0);
                    chk(RL, "rd_without_busy", rd & ~busy, 0);
                    if (mq.size() > 0 && mq[0].cyc == cyc) begin
                        e = mq.pop_front();
                        chk(RL, "mem_rd", rd, 1);
                        chk(RL, "mem_addr", maddr, e.val);
                    end else chk(RL, "mem_rd_idle", rd, 0);
                    if (en != 4'b0000) begin
                        data = (hist[(cyc - RL) % 8] >= 0) ? mem[hist[(cyc - RL) % 8]] : 4'h0;
                        for (int j = 0; j < 4; j++) if (en[3-j]) mdr[15-4*j -: 4] = data;
                    end
                    if (eq.size() > 0 && eq[0].cyc == cyc) begin
                        e = eq.pop_front();
                        chk(RL, "mdr_en", en, e.val);
                    end else chk(RL, "mdr_en_idle", en, 0);
                    if (dq.size() > 0 && dq[0].cyc == cyc) begin
                        e = dq.pop_front();
                        chk(RL, "done", done, 1);
                        chk(RL, "mdr_word", mdr, e.val);
                    end else chk(RL, "done_idle", done, 0);
                end
                hist[cyc % 8] = (rd === 1'b1) ? int'(maddr) : -1;
                #3;
                // Reference: decide what the coming edge does from the spec's timing rules.
                if (!rst_n) begin
                    mq.delete(); eq.delete(); dq.delete();
                    if (buntil > cyc) buntil = cyc;
                end else if (start && !(cyc >= bfrom && cyc <= buntil)) begin
                    e0 = cyc + 1;
                    a  = int'(addr);
                    bfrom  = e0;
                    buntil = e0 + 3 + RL;
                    for (int k = 0; k < 4; k++) begin
                        mq.push_back('{e0 + k, a * 4 + k});
                        eq.push_back('{e0 + k + RL, 8 >> k});
                    end
                    dq.push_back('{e0 + 4 + RL,
                                   int'({mem[a*4], mem[a*4+1], mem[a*4+2], mem[a*4+3]})});
                end
                pend[g] = mq.size() + eq.size() + dq.size();
            end
        end
    end

    task automatic step(input logic r, input logic s, input logic [7:0] a);
        @(negedge clk);
        #1;
        rst_n = r;
        start = s;
        addr  = a;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 4'($urandom_range(0, 15));
        mem[10'h48] = 4'hA; mem[10'h49] = 4'hB; mem[10'h4A] = 4'hC; mem[10'h4B] = 4'hD;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
        armed = 1'b1;
        idle(2);
        // Plain fetch of word 0x12 (nibbles A,B,C,D)
        step(1'b1, 1'b1, 8'h12);
        idle(12);
        // Start pulse while busy must be ignored
        step(1'b1, 1'b1, 8'h20);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h55);
        idle(12);
        // Start held high: back-to-back fetches
        step(1'b1, 1'b1, 8'h01);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 8'h02);
        idle(12);
        // Reset mid-fetch, then a clean fetch
        step(1'b1, 1'b1, 8'h33);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h12);
        idle(12);
        // Top word: no wrap into another word
        step(1'b1, 1'b1, 8'hFF);
        idle(12);
        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) == 0),
                 8'($urandom_range(0, 255)));
        idle(20);
        chk(1, "pending_events", pend[0], 0);
        chk(4, "pending_events", pend[1], 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
